// File: rtl/mem_axi_bridge.sv
// Core memory port to AXI4-Lite master, one access at a time; zero-wait slave gives 3 stall cycles per access.
// Backpressure: core held via stall_mem until DONE; optional bus timeout under `MEM_BRIDGE_TIMEOUT_EN.
module mem_axi_bridge #(
   parameter int ADDR_W         = 64,
   parameter int DATA_W         = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mem_wr_en_i,
   input  logic                mem_rd_en_i,
   input  logic [ADDR_W-1:0]   addr_mem_wr_i,
   input  logic [ADDR_W-1:0]   addr_mem_rd_i,
   input  logic [DATA_W-1:0]   data_mem_wr_i,
   input  logic [DATA_W/8-1:0] strb_mem_wr_i,
   output logic                stall_mem,
   output logic [DATA_W-1:0]   data_mem_o,
   output logic                bus_err_o,
   output logic                awvalid,
   input  logic                awready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic                wvalid,
   input  logic                wready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   input  logic                bvalid,
   output logic                bready,
   input  logic [1:0]          bresp,
   output logic                arvalid,
   input  logic                arready,
   output logic [ADDR_W-1:0]   araddr,
   input  logic                rvalid,
   output logic                rready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp
);
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

   state_t              state_q, state_d;
   logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic                rd_pend_q, rd_pend_d, err_q, err_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic                wait_st, tmo, aw_fin, w_fin;

   assign wait_st = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                    (state_q == RD_REQ) || (state_q == RD_RESP);

`ifdef MEM_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_q, tmo_d;

   always_comb begin
      tmo_d = tmo_q;
      if (state_q == IDLE) tmo_d = '0;
      else if (wait_st)    tmo_d = tmo_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) tmo_q <= '0;
      else     tmo_q <= tmo_d;
   end

   // Fires on the TIMEOUT_CYCLES-th wait cycle, so valids are up exactly that long.
   assign tmo = wait_st && (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
   assign tmo = 1'b0;
`endif

   assign aw_fin = aw_done_q || (awvalid && awready);
   assign w_fin  = w_done_q  || (wvalid && wready);

   always_comb begin
      state_d   = state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rd_pend_d = rd_pend_q;
      err_d     = 1'b0;
      awaddr_d  = awaddr_q;
      araddr_d  = araddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE: begin
            rd_pend_d = 1'b0;
            // A read deferred behind a simultaneous write wins over the still-held write enable.
            if (mem_wr_en_i && !(rd_pend_q && mem_rd_en_i)) begin
               awaddr_d  = addr_mem_wr_i;
               wdata_d   = data_mem_wr_i;
               wstrb_d   = strb_mem_wr_i;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               rd_pend_d = mem_rd_en_i;
               state_d   = WR_REQ;
            end else if (mem_rd_en_i) begin
               araddr_d = addr_mem_rd_i;
               state_d  = RD_REQ;
            end
         end
         WR_REQ: begin
            aw_done_d = aw_fin;
            w_done_d  = w_fin;
            if (aw_fin && w_fin) state_d = WR_RESP;
         end
         WR_RESP: begin
            if (bvalid) begin
               err_d   = (bresp != 2'b00);
               state_d = DONE;
            end
         end
         RD_REQ: begin
            if (arready) state_d = RD_RESP;
         end
         RD_RESP: begin
            if (rvalid) begin
               rdata_d = rdata;
               err_d   = (rresp != 2'b00);
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (tmo) begin
         state_d = DONE;
         err_d   = 1'b1;
         if ((state_q == RD_REQ) || (state_q == RD_RESP)) rdata_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rd_pend_q <= 1'b0;
         err_q     <= 1'b0;
         awaddr_q  <= '0;
         araddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rd_pend_q <= rd_pend_d;
         err_q     <= err_d;
         awaddr_q  <= awaddr_d;
         araddr_q  <= araddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
      end
   end

   assign awvalid    = (state_q == WR_REQ) && !aw_done_q;
   assign wvalid     = (state_q == WR_REQ) && !w_done_q;
   assign bready     = (state_q == WR_RESP);
   assign arvalid    = (state_q == RD_REQ);
   assign rready     = (state_q == RD_RESP);
   assign awaddr     = awaddr_q;
   assign araddr     = araddr_q;
   assign wdata      = wdata_q;
   assign wstrb      = wstrb_q;
   assign data_mem_o = rdata_q;
   assign bus_err_o  = err_q;
   assign stall_mem  = (mem_wr_en_i || mem_rd_en_i) && (state_q != DONE);

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed bench for mem_axi_bridge with a negedge-driven AXI4-Lite slave model.
module tb_mem_axi_bridge;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_wr_en_i = 1'b0, mem_rd_en_i = 1'b0;
   logic [63:0] addr_mem_wr_i = '0, addr_mem_rd_i = '0, data_mem_wr_i = '0;
   logic [7:0]  strb_mem_wr_i = '0;
   logic        stall_mem, bus_err_o;
   logic [63:0] data_mem_o;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [63:0] awaddr, wdata, araddr, rdata;
   logic [7:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int          n_cmp = 0, n_err = 0;
   int          aw_delay = 0, w_delay = 0, ar_delay = 0;
   bit          ar_never = 1'b0, b_never = 1'b0;
   logic [63:0] rdata_cfg = '0;
   logic [1:0]  rresp_cfg = 2'b00;
   int          aw_wait = 0, w_wait = 0, ar_wait = 0;
   int          aw_vld_cyc, w_vld_cyc, ar_vld_cyc, aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic [63:0] aw_seen, w_seen, ar_seen;
   logic [7:0]  strb_seen;
   int          cyc;

   always #5 clk = ~clk;

   mem_axi_bridge #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .mem_wr_en_i(mem_wr_en_i), .mem_rd_en_i(mem_rd_en_i),
      .addr_mem_wr_i(addr_mem_wr_i), .addr_mem_rd_i(addr_mem_rd_i),
      .data_mem_wr_i(data_mem_wr_i), .strb_mem_wr_i(strb_mem_wr_i),
      .stall_mem(stall_mem), .data_mem_o(data_mem_o), .bus_err_o(bus_err_o),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_cnt();
      aw_vld_cyc = 0; w_vld_cyc = 0; ar_vld_cyc = 0;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      aw_seen = '0; w_seen = '0; ar_seen = '0; strb_seen = '0;
   endtask

   // Counts stall cycles starting with the request cycle; returns in the first unstalled cycle.
   task automatic wait_done(output int n);
      n = 0;
      #1;
      while (stall_mem === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
         #1;
      end
   endtask

   // Slave: readies/responses change on negedge so they are stable at the next posedge.
   initial begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      forever begin
         @(negedge clk);
         if (awvalid === 1'b1) begin
            aw_vld_cyc++;
            awready = (aw_wait >= aw_delay);
            if (!awready) aw_wait++;
         end else begin
            awready = 1'b0; aw_wait = 0;
         end
         if (awvalid === 1'b1 && awready) begin aw_hs++; aw_seen = awaddr; end
         if (wvalid === 1'b1) begin
            w_vld_cyc++;
            wready = (w_wait >= w_delay);
            if (!wready) w_wait++;
         end else begin
            wready = 1'b0; w_wait = 0;
         end
         if (wvalid === 1'b1 && wready) begin w_hs++; w_seen = wdata; strb_seen = wstrb; end
         bvalid = (bready === 1'b1) && !b_never;
         if (bvalid) b_hs++;
         if (arvalid === 1'b1) begin
            ar_vld_cyc++;
            arready = !ar_never && (ar_wait >= ar_delay);
            if (!arready) ar_wait++;
         end else begin
            arready = 1'b0; ar_wait = 0;
         end
         if (arvalid === 1'b1 && arready) begin ar_hs++; ar_seen = araddr; end
         rvalid = (rready === 1'b1);
         rdata  = rdata_cfg;
         rresp  = rresp_cfg;
         if (rvalid) r_hs++;
      end
   end

   initial begin
      clr_cnt();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall",   64'(stall_mem), 64'd0);
      chk("rst_valids",  64'({awvalid, wvalid, arvalid}), 64'd0);
      chk("rst_readies", 64'({bready, rready}), 64'd0);
      chk("rst_awaddr",  awaddr, 64'd0);
      chk("rst_wdata",   wdata, 64'd0);
      chk("rst_wstrb",   64'(wstrb), 64'd0);
      chk("rst_data",    data_mem_o, 64'd0);
      chk("rst_err",     64'(bus_err_o), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Zero-wait read
      clr_cnt();
      rdata_cfg = 64'h1122_3344_5566_7788;
      addr_mem_rd_i = 64'h8000_0010; mem_rd_en_i = 1'b1;
      wait_done(cyc);
      chk("rd_stall_cyc", 64'(cyc), 64'd3);
      chk("rd_data",      data_mem_o, 64'h1122_3344_5566_7788);
      chk("rd_err",       64'(bus_err_o), 64'd0);
      chk("rd_araddr",    ar_seen, 64'h8000_0010);
      chk("rd_ar_vld",    64'(ar_vld_cyc), 64'd1);
      mem_rd_en_i = 1'b0;
      @(negedge clk); #1;
      chk("rd_idle_stall", 64'(stall_mem), 64'd0);

      // Write with AW delayed 4 cycles, W immediate
      clr_cnt();
      aw_delay = 4;
      addr_mem_wr_i = 64'h4000_0020; data_mem_wr_i = 64'hCAFE_F00D_1234_5678;
      strb_mem_wr_i = 8'h0F; mem_wr_en_i = 1'b1;
      wait_done(cyc);
      chk("wr_stall_cyc", 64'(cyc), 64'd7);
      chk("wr_aw_vld",    64'(aw_vld_cyc), 64'd5);
      chk("wr_w_vld",     64'(w_vld_cyc), 64'd1);
      chk("wr_hs",        64'({aw_hs[3:0], w_hs[3:0], b_hs[3:0]}), 64'h111);
      chk("wr_awaddr",    aw_seen, 64'h4000_0020);
      chk("wr_wdata",     w_seen, 64'hCAFE_F00D_1234_5678);
      chk("wr_wstrb",     64'(strb_seen), 64'h0F);
      chk("wr_data_keep", data_mem_o, 64'h1122_3344_5566_7788);
      mem_wr_en_i = 1'b0; aw_delay = 0;
      @(negedge clk); #1;
      chk("wr_one_b", 64'(b_hs), 64'd1);

      // Simultaneous write and read: write first
      clr_cnt();
      addr_mem_wr_i = 64'h100; data_mem_wr_i = 64'hA5A5_A5A5_5A5A_5A5A; strb_mem_wr_i = 8'hFF;
      addr_mem_rd_i = 64'h200; rdata_cfg = 64'h0BAD_BEEF_0000_0001;
      mem_wr_en_i = 1'b1; mem_rd_en_i = 1'b1;
      wait_done(cyc);
      chk("wr_rd_wr_cyc",  64'(cyc), 64'd3);
      chk("wr_rd_b_first", 64'(b_hs), 64'd1);
      chk("wr_rd_no_ar",   64'(ar_vld_cyc), 64'd0);
      @(negedge clk);
      wait_done(cyc);
      chk("wr_rd_rd_cyc",  64'(cyc), 64'd3);
      chk("wr_rd_data",    data_mem_o, 64'h0BAD_BEEF_0000_0001);
      chk("wr_rd_araddr",  ar_seen, 64'h200);
      chk("wr_rd_one_wr",  64'(aw_hs), 64'd1);
      mem_wr_en_i = 1'b0; mem_rd_en_i = 1'b0;
      @(negedge clk);

      // Error read response
      clr_cnt();
      rdata_cfg = 64'hDEAD; rresp_cfg = 2'b10;
      addr_mem_rd_i = 64'h300; mem_rd_en_i = 1'b1;
      wait_done(cyc);
      chk("err_cyc",  64'(cyc), 64'd3);
      chk("err_data", data_mem_o, 64'hDEAD);
      chk("err_flag", 64'(bus_err_o), 64'd1);
      mem_rd_en_i = 1'b0; rresp_cfg = 2'b00;
      @(negedge clk); #1;
      chk("err_pulse", 64'(bus_err_o), 64'd0);

      // Reset while waiting for B
      clr_cnt();
      b_never = 1'b1;
      addr_mem_wr_i = 64'h400; mem_wr_en_i = 1'b1;
      @(negedge clk); #1;
      chk("rstw_awvalid", 64'(awvalid), 64'd1);
      @(negedge clk); #1;
      chk("rstw_bready", 64'(bready), 64'd1);
      rst = 1'b1;
      @(negedge clk); #1;
      chk("rstw_bready_drop", 64'(bready), 64'd0);
      chk("rstw_valids",      64'({awvalid, wvalid}), 64'd0);
      chk("rstw_data",        data_mem_o, 64'd0);
      chk("rstw_stall",       64'(stall_mem), 64'd1);
      chk("rstw_err",         64'(bus_err_o), 64'd0);
      mem_wr_en_i = 1'b0;
      @(negedge clk); #1;
      rst = 1'b0; b_never = 1'b0;
      @(negedge clk);
      clr_cnt();
      rdata_cfg = 64'h55; addr_mem_rd_i = 64'h440; mem_rd_en_i = 1'b1;
      wait_done(cyc);
      chk("rstw_rec_cyc",  64'(cyc), 64'd3);
      chk("rstw_rec_data", data_mem_o, 64'h55);
      mem_rd_en_i = 1'b0;
      @(negedge clk);

`ifdef MEM_BRIDGE_TIMEOUT_EN
      clr_cnt();
      ar_never = 1'b1;
      addr_mem_rd_i = 64'h500; mem_rd_en_i = 1'b1;
      wait_done(cyc);
      chk("tmo_cyc",   64'(cyc), 64'd9);
      chk("tmo_ar",    64'(ar_vld_cyc), 64'd8);
      chk("tmo_no_hs", 64'(ar_hs), 64'd0);
      chk("tmo_err",   64'(bus_err_o), 64'd1);
      chk("tmo_data",  data_mem_o, 64'd0);
      mem_rd_en_i = 1'b0; ar_never = 1'b0;
      @(negedge clk); #1;
      chk("tmo_pulse", 64'(bus_err_o), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
